intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 143 ++++++++++++++
 tb/tb_intr_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl: three-source fixed-priority interrupt controller (SCTRL > DMA > EPU) for the CPU CSR block.
// Define INTR_CTRL_EDGE_EN for edge-detected sticky pending bits; the default build is level-sensitive.

`ifndef INT_ID_BITS
`define INT_ID_BITS 2
`endif
`ifndef INT_DMA
`define INT_DMA 2'd1
`endif
`ifndef INT_EPU
`define INT_EPU 2'd2
`endif
`ifndef INT_SCTRL
`define INT_SCTRL 2'd3
`endif

module intr_ctrl #(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              src_i,
  input  logic                    cfg_we_i,
  input  logic [2:0]              cfg_wdata_i,
  input  logic                    ack_i,
  input  logic                    mret_i,
  output logic                    int_taken_o,
  output logic [`INT_ID_BITS-1:0] int_id_o,
  output logic [2:0]              en_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  localparam logic [CNT_BITS-1:0] LP_CNT_LAST = CNT_BITS'(ACK_TIMEOUT - 1);

  state_t                  r_state;
  logic [2:0]              r_en;
  logic [`INT_ID_BITS-1:0] r_sel;
  logic [CNT_BITS-1:0]     r_cnt;
  logic                    r_intTaken;

  logic [2:0]              w_pend;
  logic [2:0]              w_req;
  logic [2:0]              w_enNext;
  logic [2:0]              w_selBit;
  logic [`INT_ID_BITS-1:0] w_winId;
  logic                    w_timeout;

`ifdef INTR_CTRL_EDGE_EN
  // Edge mode: one sampling stage; a pend bit is cleared only by an ack of its own source,
  // and a new rising edge in the same cycle keeps it set.
  logic [2:0] r_src;
  logic [2:0] r_pend;
  logic [2:0] w_clr;

  assign w_clr = (r_state == S_REQ && ack_i) ? w_selBit : 3'b000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src  <= 3'b000;
      r_pend <= 3'b000;
    end else begin
      r_src  <= src_i;
      r_pend <= (r_pend & ~w_clr) | (src_i & ~r_src);
    end
  end

  assign w_pend = r_pend;
`else
  assign w_pend = src_i;
`endif

  assign w_req    = w_pend & r_en;
  assign w_enNext = cfg_we_i ? cfg_wdata_i : r_en;

  always_comb begin
    w_winId = `INT_EPU;
    if (w_req[2])
      w_winId = `INT_SCTRL;
    else if (w_req[0])
      w_winId = `INT_DMA;
  end

  always_comb begin
    w_selBit = 3'b100;
    if (r_sel == `INT_DMA)
      w_selBit = 3'b001;
    else if (r_sel == `INT_EPU)
      w_selBit = 3'b010;
  end

  assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == LP_CNT_LAST);

  // A withdraw looks at the enable value being written this cycle so the request drops right
  // after the cfg write; an ack in the same cycle still takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_en       <= 3'b111;
      r_sel      <= `INT_SCTRL;
      r_cnt      <= '0;
      r_intTaken <= 1'b0;
    end else begin
      if (cfg_we_i)
        r_en <= cfg_wdata_i;
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_sel      <= w_winId;
            r_cnt      <= '0;
            r_intTaken <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_i) begin
            r_intTaken <= 1'b0;
            r_state    <= S_SERVICE;
          end else if (!(|(w_enNext & w_selBit)) || w_timeout) begin
            r_intTaken <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SERVICE: begin
          if (mret_i)
            r_state <= S_IDLE;
        end
        default: begin
          r_intTaken <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign int_taken_o = r_intTaken;
  assign int_id_o    = r_sel;
  assign en_o        = r_en;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl in its default (level-sensitive) build with ACK_TIMEOUT=4.
// Stimulus pushes the expected source ID for every presentation; a monitor pops on each rising int_taken_o.

`ifndef INT_ID_BITS
`define INT_ID_BITS 2
`endif
`ifndef INT_DMA
`define INT_DMA 2'd1
`endif
`ifndef INT_EPU
`define INT_EPU 2'd2
`endif
`ifndef INT_SCTRL
`define INT_SCTRL 2'd3
`endif

module tb_intr_ctrl;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [2:0]              src_i;
  logic                    cfg_we_i;
  logic [2:0]              cfg_wdata_i;
  logic                    ack_i;
  logic                    mret_i;
  logic                    int_taken_o;
  logic [`INT_ID_BITS-1:0] int_id_o;
  logic [2:0]              en_o;

  int errCount   = 0;
  int checkCount = 0;
  logic [`INT_ID_BITS-1:0] expQ[$];

  always #5 clk = ~clk;

  intr_ctrl #(.ACK_TIMEOUT(4), .CNT_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_i      (src_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_wdata_i(cfg_wdata_i),
    .ack_i      (ack_i),
    .mret_i     (mret_i),
    .int_taken_o(int_taken_o),
    .int_id_o   (int_id_o),
    .en_o       (en_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] src, input logic ack, input logic mret,
                               input logic we, input logic [2:0] wdata);
    src_i       = src;
    ack_i       = ack;
    mret_i      = mret;
    cfg_we_i    = we;
    cfg_wdata_i = wdata;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitTaken(input int budget, output int waited);
    waited = 0;
    while (!int_taken_o && waited < budget) begin
      step(1);
      waited++;
    end
    if (!int_taken_o) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL wait_taken: got no request after %0d cycles required int_taken_o=1", waited);
    end
  endtask

  // Accept the current request, drop the served level source, then return from the handler.
  task automatic serveOne(input logic [2:0] clrBits);
    applyStimulus(src_i & ~clrBits, 1'b1, 1'b0, 1'b0, 3'b000);
    step(1);
    ack_i = 1'b0;
    checkOutput("taken_after_ack", int_taken_o, 1'b0);
    mret_i = 1'b1;
    step(1);
    mret_i = 1'b0;
    checkOutput("taken_after_mret", int_taken_o, 1'b0);
  endtask

  // Monitor: pop on each new presentation and check the ID holds while high and while idle.
  initial begin
    logic                    prevTaken;
    logic [`INT_ID_BITS-1:0] heldId;
    logic [`INT_ID_BITS-1:0] expId;
    prevTaken = 1'b0;
    heldId    = `INT_SCTRL;
    forever begin
      @(negedge clk);
      if (rst) begin
        heldId = `INT_SCTRL;
      end else if (int_taken_o && !prevTaken) begin
        if (expQ.size() == 0) begin
          checkCount++;
          errCount++;
          $display("[TB] FAIL unexpected_request: got id %0h required no request at %0t", int_id_o, $time);
        end else begin
          expId = expQ.pop_front();
          checkOutput("presented_id", int_id_o, expId);
          heldId = expId;
        end
      end else begin
        checkOutput("id_stable", int_id_o, heldId);
      end
      prevTaken = int_taken_o;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    rst = 1'b1;
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
    #1;
    checkOutput("reset_taken", int_taken_o, 1'b0);
    checkOutput("reset_id", int_id_o, `INT_SCTRL);
    checkOutput("reset_en", en_o, 3'b111);
    step(2);
    rst = 1'b0;
    step(1);
    checkOutput("post_reset_taken", int_taken_o, 1'b0);

    // Single DMA request: presented one cycle later in level mode.
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 3'b000);
    expQ.push_back(`INT_DMA);
    waitTaken(10, waited);
    checkOutput("dma_latency", waited, 1);
    serveOne(3'b001);

    // All three at once: SCTRL, then DMA, then EPU, each after an idle cycle.
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
    expQ.push_back(`INT_SCTRL);
    expQ.push_back(`INT_DMA);
    expQ.push_back(`INT_EPU);
    waitTaken(10, waited);
    checkOutput("prio_first_latency", waited, 1);
    serveOne(3'b100);
    waitTaken(10, waited);
    checkOutput("prio_second_latency", waited, 1);
    serveOne(3'b001);
    waitTaken(10, waited);
    checkOutput("prio_third_latency", waited, 1);
    serveOne(3'b010);

    // EPU never acked: high 4 cycles, low 1, re-presented; mret during REQ is ignored.
    applyStimulus(3'b010, 1'b0, 1'b0, 1'b0, 3'b000);
    expQ.push_back(`INT_EPU);
    expQ.push_back(`INT_EPU);
    waitTaken(10, waited);
    checkOutput("timeout_latency", waited, 1);
    mret_i = 1'b1;
    step(1);
    mret_i = 1'b0;
    checkOutput("timeout_c2", int_taken_o, 1'b1);
    step(1);
    checkOutput("timeout_c3", int_taken_o, 1'b1);
    step(1);
    checkOutput("timeout_c4", int_taken_o, 1'b1);
    step(1);
    checkOutput("timeout_gap", int_taken_o, 1'b0);
    step(1);
    checkOutput("timeout_retry", int_taken_o, 1'b1);
    serveOne(3'b010);

    // DMA withdrawn by disabling it, then re-presented once re-enabled.
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 3'b000);
    expQ.push_back(`INT_DMA);
    waitTaken(10, waited);
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b1, 3'b100);
    step(1);
    cfg_we_i = 1'b0;
    checkOutput("withdraw_taken", int_taken_o, 1'b0);
    checkOutput("withdraw_en", en_o, 3'b100);
    step(2);
    checkOutput("withdraw_stays_idle", int_taken_o, 1'b0);
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b1, 3'b111);
    expQ.push_back(`INT_DMA);
    step(1);
    cfg_we_i = 1'b0;
    checkOutput("reenable_wait", int_taken_o, 1'b0);
    step(1);
    checkOutput("reenable_taken", int_taken_o, 1'b1);
    serveOne(3'b001);

    // Ack and enable clear together: ack wins; EPU held off until mret.
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 3'b000);
    expQ.push_back(`INT_DMA);
    waitTaken(10, waited);
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b1, 3'b110);
    step(1);
    ack_i    = 1'b0;
    cfg_we_i = 1'b0;
    checkOutput("ackwins_taken", int_taken_o, 1'b0);
    checkOutput("ackwins_en", en_o, 3'b110);
    step(2);
    checkOutput("service_no_nest", int_taken_o, 1'b0);
    mret_i = 1'b1;
    expQ.push_back(`INT_EPU);
    step(1);
    mret_i = 1'b0;
    checkOutput("mret_idle", int_taken_o, 1'b0);
    step(1);
    checkOutput("after_mret_taken", int_taken_o, 1'b1);
    serveOne(3'b010);

    // Reset while requesting: request drops immediately and enables return to all-on.
    applyStimulus(3'b100, 1'b0, 1'b0, 1'b1, 3'b001);
    expQ.push_back(`INT_SCTRL);
    waitTaken(10, waited);
    cfg_we_i = 1'b0;
    checkOutput("pre_reset_en", en_o, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_taken", int_taken_o, 1'b0);
    checkOutput("async_reset_en", en_o, 3'b111);
    checkOutput("async_reset_id", int_id_o, `INT_SCTRL);
    src_i = 3'b000;
    step(1);
    rst = 1'b0;
    step(2);
    checkOutput("final_idle", int_taken_o, 1'b0);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
